// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: funct3 encodings,
// the one-hot control state and small operand-classification helpers.
package mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_MUL  = 5'b00010,
        S_DIV  = 5'b00100,
        S_FIX  = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    // Only plain MUL returns the low half of the product; every MULH* variant the high half.
    function automatic logic mul_takes_high(input logic [2:0] op);
        return op[1:0] != 2'b00;
    endfunction

    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, XLEN steps.
// done is high during the step that produces the final quotient/remainder.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  den_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    diff;

    // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    always_comb begin
        rem_sh = {remainder, quotient[XLEN-1]};
        diff   = rem_sh - {1'b0, den_q};
    end

    assign done = step && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remainder <= '0;
            quotient  <= '0;
            den_q     <= '0;
            cnt_q     <= '0;
        end else if (start) begin
            remainder <= '0;
            quotient  <= dividend;
            den_q     <= divisor;
            cnt_q     <= CNT_W'(XLEN - 1);
        end else if (step) begin
            if (!diff[XLEN]) begin
                remainder <= diff[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end else begin
                remainder <= rem_sh[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M/RV64M multiply/divide unit with valid/ready on both sides and flush.
// Optional macro MDU_DIV_REUSE_EN adds a one-entry cache of the last iterative divide.
//
// Handshake: a request is taken when in_valid && in_ready && !flush; a result is
// taken when out_valid && out_ready. out_valid holds until taken, flush or rst.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [4:0]      dbg_state
);

    localparam int MUL_ITERS = XLEN / MUL_BITS;
    localparam int CNT_W     = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state_q, state_d;

    logic            accept, mul_step, div_start, div_step, div_done;
    logic            a_neg, b_neg, div_by_zero, overflow, special, hit;
    logic [XLEN-1:0] mag_a, mag_b, fast_val;

    logic [2:0]        op_q;
    logic              neg_q_q, neg_r_q, fast_q;
    logic [XLEN-1:0]   fast_res_q, mcand_q, mplier_q;
    logic [2*XLEN-1:0] acc_q, acc_next, prod_fix;
    logic [CNT_W-1:0]  cnt_q;

    logic [XLEN+MUL_BITS-1:0]   partial;
    logic [2*XLEN+MUL_BITS-1:0] acc_sum;
    logic [XLEN-1:0]            div_quo, div_rem, quo_fix, rem_fix, fix_val;

`ifdef MDU_DIV_REUSE_EN
    logic            c_valid, c_op0;
    logic [XLEN-1:0] c_rs1, c_rs2, c_quo, c_rem, key_rs1_q, key_rs2_q;
`endif

    assign dbg_state = state_q;

    // Request classification, evaluated combinationally in the accept cycle.
    always_comb begin
        a_neg       = rs1_is_signed(op) && rs1[XLEN-1];
        b_neg       = rs2_is_signed(op) && rs2[XLEN-1];
        mag_a       = a_neg ? -rs1 : rs1;
        mag_b       = b_neg ? -rs2 : rs2;
        div_by_zero = op[2] && (rs2 == '0);
        overflow    = op[2] && !op[0] && (rs1 == MOST_NEG) && (rs2 == '1);
        special     = div_by_zero || overflow;
`ifdef MDU_DIV_REUSE_EN
        hit = c_valid && op[2] && (rs1 == c_rs1) && (rs2 == c_rs2) && (op[0] == c_op0);
`else
        hit = 1'b0;
`endif
        fast_val = '0;
`ifdef MDU_DIV_REUSE_EN
        if (hit) fast_val = op[1] ? c_rem : c_quo;
`endif
        if (overflow)    fast_val = op[1] ? '0 : rs1;
        if (div_by_zero) fast_val = op[1] ? rs1 : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = (special || hit) ? S_FIX : (op[2] ? S_DIV : S_MUL);
                S_MUL:   if (cnt_q == '0) state_d = S_FIX;
                S_DIV:   if (div_done) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        accept    = in_ready && in_valid && !flush;
        mul_step  = (state_q == S_MUL);
        div_step  = (state_q == S_DIV);
        div_start = accept && op[2] && !special && !hit;
    end

    // Shift-add: fold MUL_BITS multiplier bits into the top half, then shift right.
    always_comb begin
        partial  = {{MUL_BITS{1'b0}}, mcand_q} * {{XLEN{1'b0}}, mplier_q[MUL_BITS-1:0]};
        acc_sum  = {{MUL_BITS{1'b0}}, acc_q} + {partial, {XLEN{1'b0}}};
        acc_next = acc_sum[2*XLEN+MUL_BITS-1:MUL_BITS];
    end

    mdu_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        prod_fix = neg_q_q ? -acc_q : acc_q;
        quo_fix  = neg_q_q ? -div_quo : div_quo;
        rem_fix  = neg_r_q ? -div_rem : div_rem;
        if (fast_q)
            fix_val = fast_res_q;
        else if (!op_q[2])
            fix_val = mul_takes_high(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        else if (op_q[1])
            fix_val = rem_fix;
        else
            fix_val = quo_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            fast_q     <= 1'b0;
            fast_res_q <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            result     <= '0;
        end else begin
            if (accept) begin
                op_q       <= op;
                neg_q_q    <= a_neg ^ b_neg;
                neg_r_q    <= a_neg;
                fast_q     <= special || hit;
                fast_res_q <= fast_val;
                acc_q      <= '0;
                mcand_q    <= mag_b;
                mplier_q   <= mag_a;
                cnt_q      <= CNT_W'(MUL_ITERS - 1);
            end else if (mul_step) begin
                acc_q    <= acc_next;
                mplier_q <= mplier_q >> MUL_BITS;
                cnt_q    <= cnt_q - CNT_W'(1);
            end
            if (state_q == S_FIX) result <= fix_val;
        end
    end

`ifdef MDU_DIV_REUSE_EN
    // Entry is refreshed only by divides that actually iterated; special cases never need it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid   <= 1'b0;
            c_op0     <= 1'b0;
            c_rs1     <= '0;
            c_rs2     <= '0;
            c_quo     <= '0;
            c_rem     <= '0;
            key_rs1_q <= '0;
            key_rs2_q <= '0;
        end else if (flush) begin
            c_valid <= 1'b0;
        end else begin
            if (accept) begin
                key_rs1_q <= rs1;
                key_rs2_q <= rs2;
            end
            if ((state_q == S_FIX) && op_q[2] && !fast_q) begin
                c_valid <= 1'b1;
                c_op0   <= op_q[0];
                c_rs1   <= key_rs1_q;
                c_rs2   <= key_rs2_q;
                c_quo   <= quo_fix;
                c_rem   <= rem_fix;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised and directed bench for mdu_seq (XLEN=32, MUL_BITS=4) against an
// arithmetic reference model of the RV32M rules, result latency and reuse behaviour.
module tb_mdu_seq;

    localparam int XLEN     = 32;
    localparam int MUL_BITS = 4;
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;
`ifdef MDU_DIV_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;
    logic [4:0]  dbg_state;

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];

    bit          m_cvalid = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_op0 = 1'b0;

    mdu_seq #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset support
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: RISC-V M-extension arithmetic on 64-bit integers.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (o)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit hit;
        if (!o[2]) return XLEN / MUL_BITS + 2;
        if (b == 0) return 2;
        if (!o[0] && a == MOST_NEG && b == 32'hFFFF_FFFF) return 2;
        hit = m_cvalid && (a == m_a) && (b == m_b) && (o[0] == m_op0);
        if (hit && REUSE) return 2;
        return XLEN + 2;
    endfunction

    // Driver: issue one request, collect and score its result, optionally stall the output.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int          t0, exp_lat;
        bit          seen;
        logic [31:0] got;
        exp_q.push_back(ref_result(o, a, b));
        exp_lat = ref_latency(o, a, b);
        @(negedge clk);
        check("in_ready_before_issue", 64'(in_ready), 64'(1));
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = (hold == 0);
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            check("out_valid_timeout", 64'(0), 64'(1));
            void'(exp_q.pop_front());
            flush = 1'b1; @(negedge clk); flush = 1'b0; out_ready = 1'b1;
            m_cvalid = 1'b0;
            return;
        end
        check($sformatf("latency op%0d", o), 64'(cyc - t0), 64'(exp_lat));
        got = result;
        check($sformatf("result op%0d a=%h b=%h", o, a, b), 64'(got), 64'(exp_q.pop_front()));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_result_stable", 64'(result), 64'(got));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        if (o[2] && exp_lat == XLEN + 2) begin
            m_cvalid = 1'b1; m_a = a; m_b = b; m_op0 = o[0];
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return MOST_NEG;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b, last_a, last_b;
        int          t0;
        bit          seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        rst = 1'b0;

        // Directed cases
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b101, 32'd100, 32'd7, 5);
        run_op(3'b100, 32'd5, 32'd0, 0);
        run_op(3'b111, 32'd5, 32'd0, 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b100, 32'd100, 32'd7, 0);
        run_op(3'b110, 32'd100, 32'd7, 0);

        // flush together with a request: nothing is accepted
        @(negedge clk);
        check("idle_before_flush_req", 64'(in_ready), 64'(1));
        op = 3'b000; rs1 = 32'd3; rs2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; m_cvalid = 1'b0;
        check("flush_req_busy", 64'(busy), 64'(0));
        check("flush_req_in_ready", 64'(in_ready), 64'(1));
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        check("flush_req_no_result", 64'(seen), 64'(0));

        run_op(3'b110, 32'd100, 32'd7, 0);

        // flush in the 10th cycle of an iterating divide
        @(negedge clk);
        op = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1; t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc - t0 < 10) @(negedge clk);
        check("div_cycle10_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; m_cvalid = 1'b0;
        check("flush_div_in_ready", 64'(in_ready), 64'(1));
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        check("flush_div_no_result", 64'(seen), 64'(0));

        // flush while a result waits: it is discarded
        @(negedge clk);
        op = 3'b000; rs1 = 32'd6; rs2 = 32'd9; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check("held_result_reached", 64'(seen), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        check("flush_done_out_valid", 64'(out_valid), 64'(0));
        check("flush_done_in_ready", 64'(in_ready), 64'(1));

        // Randomised operations, with repeated divide operands to exercise reuse
        last_a = 32'd100; last_b = 32'd7;
        for (int n = 0; n < 60; n++) begin
            r_op = 3'($urandom_range(0, 7));
            if (r_op[2] && $urandom_range(0, 2) == 0) begin
                r_a = last_a; r_b = last_b;
            end else begin
                r_a = pick(); r_b = pick();
            end
            if (r_op[2]) begin last_a = r_a; last_b = r_b; end
            run_op(r_op, r_a, r_b, $urandom_range(0, 2));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised sequential multiply/divide unit executing the RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the ALU in the execute stage and talks to the pipeline over valid/ready handshakes, with one operation outstanding at a time. It adds the following:
- configurable operand width;
- a configurable multiplier radix;
- full RISC-V divide-by-zero and overflow semantics;
- output backpressure;
- a pipeline flush.

## Interface
Parameters:
- XLEN, 32: operand/result width; legal values are 32 and 64.
- MUL_BITS, 4: multiplier bits retired per cycle; legal values are 1, 2, 4, 8; must divide XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  abort any operation in flight.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; equals (state==IDLE).
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  multiplier / dividend.
- rs2  in  XLEN  multiplicand / divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  rd value.
- busy  out  1  state != IDLE.

## Operation
State machine, one-hot in RTL:
- **IDLE**
  - On in_valid && !flush: latch op; capture operand magnitudes and result sign.
  - Go to MUL (op[2]=0), to DIV (op[2]=1), or straight to FIX for a special case or a reuse hit.
- **MUL**
  - Shift-add of unsigned magnitudes, MUL_BITS multiplier bits per cycle.
  - 2*XLEN accumulator.
  - Exactly XLEN/MUL_BITS cycles; no early exit.
- **DIV**
  - Restoring division of magnitudes, 1 quotient bit per cycle.
  - Exactly XLEN cycles.
- **FIX**
  - Apply sign negation; select result:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register result.
- **DONE**
  - out_valid=1; result held stable.
  - Go to IDLE on out_ready.

Signedness:
- MULH: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU/DIVU/REMU: both unsigned.
- DIV/REM: both signed.
- Quotient sign is rs1^rs2.
- Remainder takes the sign of rs1.

Special cases, resolved at accept with no iteration:
- Divisor 0: quotient is all-ones; remainder is rs1.
- Signed overflow (rs1 = most-negative value, rs2 = -1): quotient is rs1; remainder is 0.

flush:
- In any state, the next edge goes to IDLE; out_valid drops; any result not yet taken is discarded.
- flush takes priority over a simultaneous in_valid; that request is not accepted.

Reset (asynchronous):
- State goes to IDLE, so in_ready=1, busy=0.
- out_valid=0, result=0.
- All datapath registers are cleared.

## Timing
Let T be the cycle in which in_valid && in_ready is sampled high. out_valid is first high in:
- Multiply: cycle T+XLEN/MUL_BITS+2 (T+10 for XLEN=32, MUL_BITS=4).
- Divide: cycle T+XLEN+2 (T+34 for XLEN=32).
- Special case or reuse hit: cycle T+2.

Handshake rules:
- Result transfers on out_valid && out_ready.
- in_ready rises in the following cycle; there is no same-cycle turnaround.
- out_valid never drops without a transfer, except on flush or rst.

## Configuration
MDU_DIV_REUSE_EN
- **Defined:** a one-entry cache holds:
  - rs1, rs2, op[0];
  - the final quotient and remainder of the last completed DIV/DIVU/REM/REMU.
  - A divide request whose rs1, rs2 and op[0] match the entry is a hit: IDLE goes to FIX, out_valid at T+2.
  - The entry is invalidated on rst and on flush.
  - The entry is overwritten by each completed divide.
  - Multiplies do not touch the entry.
- **Undefined:** there is no cache; every non-special divide takes XLEN+2 cycles.

## Structure
- Package mdu_pkg holds:
  - op encoding constants;
  - state enum;
  - a helper function for the MUL/MULH select.
- Sub-module mdu_divider holds the restoring-division iteration datapath:
  - remainder/quotient shift registers;
  - a compare-subtract step;
  - a start/step/done interface.
- The multiply datapath, special-case detection, sign fix and reuse cache stay in mdu_seq.

## Test plan
All scenarios run with XLEN=32, MUL_BITS=4.
- **Signed multiply:** MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB; out_valid first in cycle T+10.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- **Signed divide:** DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; out_valid in cycle T+34.
- **Special cases, each with out_valid at T+2:**
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- **Backpressure and flush:**
  - Hold out_ready=0 for 5 cycles: result stable, in_ready=0 throughout.
  - flush in the 10th cycle of a DIV: out_valid never rises; in_ready=1 the next cycle.
  - flush concurrent with in_valid: the request is not accepted.
- **Reuse (MDU_DIV_REUSE_EN):** DIV 100 / 7 -> 14, then REM 100 / 7 -> 2 at T+2. With the macro undefined, the REM completes at T+34. After a flush, the repeated REM completes at T+34.
